// File: rtl/ok_ifc_pkg.sv
// ---------------------------------------------------------------------------
// ok_ifc_pkg
// Shared definitions for the OK host-interface pipe buffers (pipe-out and
// pipe-in sides): word field widths, FIFO/block geometry, the upstream NOP
// word and the block-transfer state encoding.
// ---------------------------------------------------------------------------
package ok_ifc_pkg;

    localparam int Ncode   = 8;    // code field width (word MSBs)
    localparam int Ndata   = 24;   // data field width
    localparam int NOPcode = 64;   // upstream NOP code
    localparam int Nfifo   = 9;    // log2 FIFO depth
    localparam int Nblock  = 7;    // log2 block size

    localparam int WORD_W  = Ncode + Ndata;

    // NOP word: NOP code in the code field, zero data
    localparam logic [WORD_W-1:0] NOP_WORD = {Ncode'(NOPcode), Ndata'(0)};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        XFER  = 2'd2
    } bt_state_e;

endpackage

// File: rtl/ok_bt_pipe_out_buffer_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO: rd_data always presents the oldest stored
// word; rd_en consumes it.
// Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset (empties the FIFO)
//   wr_en    - push wr_data (ignored when full)
//   wr_data  - word to store
//   rd_en    - pop the head word (ignored when empty)
//   rd_data  - head word (show-ahead)
//   usedw    - occupancy, 0..2^AW
//   full     - occupancy == 2^AW
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int W  = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   usedw,
    output logic          full
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign usedw   = cnt_q;
    assign rd_data = mem[rd_ptr_q];

    always_comb begin
        wr_ok    = wr_en && !full;
        rd_ok    = rd_en && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ok_bt_pipe_out_buffer.sv
// ---------------------------------------------------------------------------
// ok_bt_pipe_out_buffer
// FPGA->host path: buffers core words in a 512-word FIFO and serves them to
// an okBTPipeOut endpoint in fixed 128-word blocks. A partial block is
// committed after FLUSH_CYCLES idle cycles and padded with NOP words.
// Ports:
//   clk           - okClk
//   reset         - asynchronous active-low reset
//   core_in_v/d/a - core channel: valid, data {code,data}, ack (v&&a = push)
//   ep_read       - endpoint read strobe, one per word
//   ep_datain     - registered word to host (valid the cycle after ep_read)
//   ep_ready      - a full block is committed and may be transferred
//   fifo_count    - FIFO occupancy
//   protocol_err  - sticky: read outside a block transfer
// ---------------------------------------------------------------------------
module ok_bt_pipe_out_buffer
    import ok_ifc_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_in_v,
    input  logic [WORD_W-1:0] core_in_d,
    output logic              core_in_a,
    input  logic              ep_read,
    output logic [WORD_W-1:0] ep_datain,
    output logic              ep_ready,
    output logic [Nfifo:0]    fifo_count,
    output logic              protocol_err
);

    localparam int BLOCK = 1 << Nblock;
    localparam int CW    = Nblock + 1;
    localparam int TW    = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [TW-1:0] FLUSH_T = TW'(FLUSH_CYCLES);

    bt_state_e         state_q, state_d;
    logic [CW-1:0]     real_q, real_d;   // FIFO words still owed to this block
    logic [CW-1:0]     pad_q, pad_d;     // NOP words still owed to this block
    logic [TW-1:0]     timer_q, timer_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              perr_q, perr_d;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic [WORD_W-1:0] fifo_q;
    logic [Nfifo:0]    usedw;

    assign core_in_a    = ~fifo_full & reset;
    assign push         = core_in_v & core_in_a;
    assign ep_ready     = (state_q == READY);
    assign ep_datain    = dout_q;
    assign fifo_count   = usedw;
    assign protocol_err = perr_q;

    sync_fifo #(
        .W  (WORD_W),
        .AW (Nfifo)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset),
        .wr_en   (push),
        .wr_data (core_in_d),
        .rd_en   (pop),
        .rd_data (fifo_q),
        .usedw   (usedw),
        .full    (fifo_full)
    );

    always_comb begin
        state_d = state_q;
        real_d  = real_q;
        pad_d   = pad_q;
        timer_d = timer_q;
        dout_d  = dout_q;
        perr_d  = perr_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ep_read) begin
                    dout_d = NOP_WORD;
                    perr_d = 1'b1;
                end
                if (usedw >= (Nfifo+1)'(BLOCK)) begin
                    state_d = READY;
                    real_d  = CW'(BLOCK);
                    pad_d   = '0;
                    timer_d = '0;
                end else if ((FLUSH_CYCLES != 0) && (usedw != '0) && (timer_q == FLUSH_T)) begin
                    // Count is below BLOCK here, so its low CW bits are exact.
                    state_d = READY;
                    real_d  = usedw[CW-1:0];
                    pad_d   = CW'(BLOCK) - usedw[CW-1:0];
                    timer_d = '0;
                end else if (push || (usedw == '0)) begin
                    timer_d = '0;
                end else if (timer_q != FLUSH_T) begin
                    timer_d = timer_q + TW'(1);
                end
            end

            READY, XFER: begin
                timer_d = '0;
                if (ep_read) begin
                    if (real_q != '0) begin
                        pop    = 1'b1;
                        dout_d = fifo_q;
                        real_d = real_q - CW'(1);
                    end else begin
                        dout_d = NOP_WORD;
                        pad_d  = pad_q - CW'(1);
                    end
                    // Last owed word of the block: return to IDLE.
                    if (({1'b0, real_q} + {1'b0, pad_q}) == (CW+1)'(1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = XFER;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            real_q  <= '0;
            pad_q   <= '0;
            timer_q <= '0;
            dout_q  <= NOP_WORD;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            real_q  <= real_d;
            pad_q   <= pad_d;
            timer_q <= timer_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
        end
    end

endmodule

// File: tb/tb_ok_bt_pipe_out_buffer.sv
module tb_ok_bt_pipe_out_buffer;

    localparam int          FLUSH = 16;
    localparam logic [31:0] NOP   = 32'h4000_0000;  // {8'd64, 24'h0}

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_in_v = 1'b0;
    logic [31:0] core_in_d = '0;
    logic        core_in_a;
    logic        ep_read = 1'b0;
    logic [31:0] ep_datain;
    logic        ep_ready;
    logic [9:0]  fifo_count;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];        // words accepted by the buffer, not yet delivered
    logic [31:0] last_word;

    always #5 clk = ~clk;

    ok_bt_pipe_out_buffer #(.FLUSH_CYCLES(FLUSH)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_in_v    (core_in_v),
        .core_in_d    (core_in_d),
        .core_in_a    (core_in_a),
        .ep_read      (ep_read),
        .ep_datain    (ep_datain),
        .ep_ready     (ep_ready),
        .fifo_count   (fifo_count),
        .protocol_err (protocol_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle();
        core_in_v = 1'b0;
        ep_read   = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_n(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            core_in_v = 1'b1;
            core_in_d = w;
            if (core_in_a) q.push_back(w);
            @(negedge clk);
        end
        core_in_v = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ep_ready && n < budget) begin
            idle_cycle();
            n++;
        end
        check("ready_up", {31'b0, ep_ready}, 32'd1);
    endtask

    // One 128-read block; the block owes min(queued,128) real words then NOPs.
    task automatic read_block(input bit push_during, input bit chk_count);
        int real_n;
        logic [31:0] exp;
        logic [31:0] w;
        real_n = (q.size() < 128) ? q.size() : 128;
        for (int i = 0; i < 128; i++) begin
            ep_read = 1'b1;
            if (push_during) begin
                w = $urandom;
                core_in_v = 1'b1;
                core_in_d = w;
                if (core_in_a) q.push_back(w);
            end
            exp = (i < real_n) ? q.pop_front() : NOP;
            @(negedge clk);
            check("blk_word", ep_datain, exp);
            if (i == 0) check("ready_drop", {31'b0, ep_ready}, 32'd0);
            if (chk_count) begin
                check("fifo_count", {22'b0, fifo_count}, q.size());
                check("ack", {31'b0, core_in_a}, (q.size() < 512) ? 32'd1 : 32'd0);
            end
            last_word = exp;
        end
        ep_read   = 1'b0;
        core_in_v = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, ep_ready}, 32'd0);
        check({tag, "_datain"}, ep_datain, NOP);
        check({tag, "_ack"}, {31'b0, core_in_a}, 32'd0);
        check({tag, "_count"}, {22'b0, fifo_count}, 32'd0);
        check({tag, "_perr"}, {31'b0, protocol_err}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        @(negedge clk);

        // 1: one full block, back-to-back pushes
        push_n(128);
        for (int k = 0; k < 2 && !ep_ready; k++) idle_cycle();
        check("t1_ready", {31'b0, ep_ready}, 32'd1);
        read_block(1'b0, 1'b1);
        check("t1_ready_low", {31'b0, ep_ready}, 32'd0);
        check("t1_empty", {22'b0, fifo_count}, 32'd0);
        idle_cycle();
        check("t1_hold", ep_datain, last_word);

        // 2: partial block flushed after exactly FLUSH idle cycles
        push_n(5);
        for (int k = 0; k < FLUSH; k++) idle_cycle();
        check("t2_not_yet", {31'b0, ep_ready}, 32'd0);
        idle_cycle();
        check("t2_flush", {31'b0, ep_ready}, 32'd1);
        read_block(1'b0, 1'b1);

        // 3: fill the FIFO, back-pressure, then 640 words across 5 blocks
        push_n(512);
        check("t3_full_ack", {31'b0, core_in_a}, 32'd0);
        check("t3_full_cnt", {22'b0, fifo_count}, 32'd512);
        wait_ready(4);
        read_block(1'b0, 1'b1);
        push_n(128);
        check("t3_refull", {22'b0, fifo_count}, 32'd512);
        for (int b = 0; b < 4; b++) begin
            wait_ready(4);
            read_block(1'b0, 1'b1);
        end
        check("t3_drained", {22'b0, fifo_count}, 32'd0);

        // 5: read in IDLE (datain currently a real word)
        check("t5_perr_pre", {31'b0, protocol_err}, 32'd0);
        push_n(3);
        ep_read = 1'b1;
        @(negedge clk);
        ep_read = 1'b0;
        check("t5_datain", ep_datain, NOP);
        check("t5_perr", {31'b0, protocol_err}, 32'd1);
        check("t5_count", {22'b0, fifo_count}, 32'd3);
        wait_ready(FLUSH + 4);
        read_block(1'b0, 1'b1);

        // 4: pushes during XFER only land in later blocks
        push_n(200);
        for (int b = 0; b < 2; b++) begin
            wait_ready(4);
            read_block(1'b1, 1'b1);
        end
        wait_ready(4);
        read_block(1'b0, 1'b1);
        wait_ready(FLUSH + 4);
        read_block(1'b0, 1'b1);
        check("t4_drained", {22'b0, fifo_count}, 32'd0);

        // 6: reset mid-block, then a clean block
        push_n(128);
        wait_ready(4);
        for (int i = 0; i < 60; i++) begin
            logic [31:0] exp;
            ep_read = 1'b1;
            exp = q.pop_front();
            @(negedge clk);
            check("t6_word", ep_datain, exp);
        end
        ep_read = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("t6_rst");
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_n(128);
        wait_ready(4);
        read_block(1'b0, 1'b1);
        check("t6_perr", {31'b0, protocol_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
